// File: rtl/lockstep_pkg.sv
// lockstep_pkg: shared types, group indices and compare helper for the lockstep checker
package lockstep_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        CHECK,
        ERROR,
        HALT
    } state_t;

    localparam int G0_INSTR = 0;
    localparam int G1_DCTRL = 1;
    localparam int G2_DDATA = 2;
    localparam int G3_BUSY  = 3;

    typedef struct packed {
        logic        instr_req;
        logic [31:0] instr_addr;
        logic        data_req;
        logic        data_we;
        logic [3:0]  data_be;
        logic [31:0] data_addr;
        logic [31:0] data_wdata;
        logic        core_busy;
    } core_bundle_t;

    function automatic logic [3:0] diff_groups(core_bundle_t a, core_bundle_t b);
        logic both_i;
        logic both_d;
        logic both_w;
        both_i = a.instr_req & b.instr_req;
        both_d = a.data_req & b.data_req;
        both_w = both_d & a.data_we & b.data_we;
        diff_groups = '0;
        diff_groups[G0_INSTR] = (a.instr_req != b.instr_req) | (both_i & (a.instr_addr != b.instr_addr));
        diff_groups[G1_DCTRL] = (a.data_req != b.data_req) | (both_d & ((a.data_we != b.data_we) | (a.data_be != b.data_be)));
        diff_groups[G2_DDATA] = (both_d & (a.data_addr != b.data_addr)) | (both_w & (a.data_wdata != b.data_wdata));
        diff_groups[G3_BUSY]  = a.core_busy != b.core_busy;
    endfunction

endpackage

// File: rtl/lockstep_if.sv
// lockstep_if: both core buses, control inputs and checker status outputs
interface lockstep_if;

    logic        enable_i;
    logic        clear_i;
    logic        instr_req_cls1_i;
    logic        instr_req_cls2_i;
    logic [31:0] instr_addr_cls1_i;
    logic [31:0] instr_addr_cls2_i;
    logic        data_req_cls1_i;
    logic        data_req_cls2_i;
    logic        data_we_cls1_i;
    logic        data_we_cls2_i;
    logic [3:0]  data_be_cls1_i;
    logic [3:0]  data_be_cls2_i;
    logic [31:0] data_addr_cls1_i;
    logic [31:0] data_addr_cls2_i;
    logic [31:0] data_wdata_cls1_i;
    logic [31:0] data_wdata_cls2_i;
    logic        core_busy_cls1_i;
    logic        core_busy_cls2_i;
    logic        mismatch_o;
    logic        err_flag_o;
    logic [7:0]  err_count_o;
    logic [3:0]  err_src_o;
    logic        halt_o;

    modport master (
        output enable_i, clear_i,
        output instr_req_cls1_i, instr_req_cls2_i, instr_addr_cls1_i, instr_addr_cls2_i,
        output data_req_cls1_i, data_req_cls2_i, data_we_cls1_i, data_we_cls2_i,
        output data_be_cls1_i, data_be_cls2_i, data_addr_cls1_i, data_addr_cls2_i,
        output data_wdata_cls1_i, data_wdata_cls2_i, core_busy_cls1_i, core_busy_cls2_i,
        input  mismatch_o, err_flag_o, err_count_o, err_src_o, halt_o
    );

    modport slave (
        input  enable_i, clear_i,
        input  instr_req_cls1_i, instr_req_cls2_i, instr_addr_cls1_i, instr_addr_cls2_i,
        input  data_req_cls1_i, data_req_cls2_i, data_we_cls1_i, data_we_cls2_i,
        input  data_be_cls1_i, data_be_cls2_i, data_addr_cls1_i, data_addr_cls2_i,
        input  data_wdata_cls1_i, data_wdata_cls2_i, core_busy_cls1_i, core_busy_cls2_i,
        output mismatch_o, err_flag_o, err_count_o, err_src_o, halt_o
    );

endinterface

// File: rtl/lockstep_delay_line.sv
// lockstep_delay_line: DELAY-stage register line for the leading core's bundle
module lockstep_delay_line
    import lockstep_pkg::*;
#(
    parameter int DELAY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  core_bundle_t d_i,
    output core_bundle_t q_o
);

    if (DELAY == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_pipe
        core_bundle_t pipe_q [DELAY];
        // shift the bundle one stage per cycle, cleared on reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= d_i;
                for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign q_o = pipe_q[DELAY-1];
    end

endmodule

// File: rtl/lockstep_checker.sv
// lockstep_checker: compares the lagging cls2 core against a delayed copy of cls1
module lockstep_checker
    import lockstep_pkg::*;
#(
    parameter int DELAY      = 2,
    parameter int ERR_THRESH = 4
) (
    input  logic      clk,
    input  logic      rst,
    lockstep_if.slave bus
);

    localparam logic [7:0] THRESH    = 8'(ERR_THRESH);
    localparam logic [2:0] WARM_INIT = 3'(DELAY > 0 ? DELAY - 1 : 0);
    localparam state_t     START     = (DELAY == 0) ? CHECK : WARMUP;

    core_bundle_t cls1, cls2, cls1_dly;
    logic [3:0]   diff;
    state_t       state_q, state_d;
    logic [2:0]   wcnt_q, wcnt_d;
    logic [7:0]   count_q, count_d;
    logic         flag_q, flag_d;
    logic [3:0]   src_q, src_d;
    logic         mismatch_q, mismatch_d;

    assign cls1 = '{instr_req: bus.instr_req_cls1_i, instr_addr: bus.instr_addr_cls1_i,
                    data_req: bus.data_req_cls1_i, data_we: bus.data_we_cls1_i,
                    data_be: bus.data_be_cls1_i, data_addr: bus.data_addr_cls1_i,
                    data_wdata: bus.data_wdata_cls1_i, core_busy: bus.core_busy_cls1_i};
    assign cls2 = '{instr_req: bus.instr_req_cls2_i, instr_addr: bus.instr_addr_cls2_i,
                    data_req: bus.data_req_cls2_i, data_we: bus.data_we_cls2_i,
                    data_be: bus.data_be_cls2_i, data_addr: bus.data_addr_cls2_i,
                    data_wdata: bus.data_wdata_cls2_i, core_busy: bus.core_busy_cls2_i};

    lockstep_delay_line #(.DELAY(DELAY)) u_dly (
        .clk (clk),
        .rst (rst),
        .d_i (cls1),
        .q_o (cls1_dly)
    );

    assign diff = diff_groups(cls1_dly, cls2);

    // state and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            count_q    <= '0;
            flag_q     <= 1'b0;
            src_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            count_q    <= count_d;
            flag_q     <= flag_d;
            src_q      <= src_d;
            mismatch_q <= mismatch_d;
        end
    end

    // clear beats everything; disable parks in IDLE unless halted; compares count only in CHECK/ERROR
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        count_d    = count_q;
        flag_d     = flag_q;
        src_d      = src_q;
        mismatch_d = 1'b0;
        if (bus.clear_i) begin
            state_d = bus.enable_i ? START : IDLE;
            wcnt_d  = WARM_INIT;
            count_d = '0;
            flag_d  = 1'b0;
            src_d   = '0;
        end else if (state_q != HALT && !bus.enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = START;
                    wcnt_d  = WARM_INIT;
                end
                WARMUP: begin
                    state_d = (wcnt_q == 3'd0) ? CHECK : WARMUP;
                    wcnt_d  = wcnt_q - 3'd1;
                end
                CHECK, ERROR: begin
                    if (|diff) begin
                        mismatch_d = 1'b1;
                        flag_d     = 1'b1;
                        src_d      = flag_q ? src_q : diff;
                        count_d    = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                        state_d    = (count_d >= THRESH) ? HALT : ERROR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mismatch_o  = mismatch_q;
    assign bus.err_flag_o  = flag_q;
    assign bus.err_count_o = count_q;
    assign bus.err_src_o   = src_q;
    assign bus.halt_o      = state_q == HALT;

endmodule

// File: tb/tb_lockstep_checker.sv
// tb_lockstep_checker: random and directed checking of lockstep_checker against a behavioural model
module tb_lockstep_checker;
    import lockstep_pkg::*;

    localparam int DLY = 2;
    localparam int TH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lockstep_if bus();

    lockstep_checker #(.DELAY(DLY), .ERR_THRESH(TH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    core_bundle_t c1, c2;
    logic         en, clr;
    core_bundle_t hist[$];

    bit         m_active, m_halt, m_flag, m_mis;
    int         m_warm, m_cnt;
    logic [3:0] m_src;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_halt = 0; m_flag = 0; m_mis = 0;
        m_warm = 0; m_cnt = 0; m_src = '0;
        hist = {};
        repeat (DLY) hist.push_back('0);
    endtask

    function automatic core_bundle_t aligned();
        return (DLY == 0) ? c1 : hist[0];
    endfunction

    function automatic logic [3:0] ref_groups(core_bundle_t a, core_bundle_t b);
        logic [3:0] g = 4'b0;
        if (a.instr_req != b.instr_req) g[0] = 1'b1;
        else if (a.instr_req && a.instr_addr != b.instr_addr) g[0] = 1'b1;
        if (a.data_req != b.data_req) g[1] = 1'b1;
        else if (a.data_req) begin
            if (a.data_we != b.data_we || a.data_be != b.data_be) g[1] = 1'b1;
            if (a.data_addr != b.data_addr) g[2] = 1'b1;
            if (a.data_we && b.data_we && a.data_wdata != b.data_wdata) g[2] = 1'b1;
        end
        if (a.core_busy != b.core_busy) g[3] = 1'b1;
        return g;
    endfunction

    task automatic model_edge(core_bundle_t al);
        logic [3:0] d;
        d = ref_groups(al, c2);
        m_mis = 0;
        if (clr) begin
            m_cnt = 0; m_flag = 0; m_src = '0; m_halt = 0;
            m_active = en; m_warm = DLY;
        end else if (m_halt) begin
            m_mis = 0;
        end else if (!en) begin
            m_active = 0;
        end else if (!m_active) begin
            m_active = 1; m_warm = DLY;
        end else if (m_warm > 0) begin
            m_warm--;
        end else if (d != 0) begin
            m_mis = 1;
            if (!m_flag) m_src = d;
            m_flag = 1;
            m_cnt  = (m_cnt == 255) ? 255 : m_cnt + 1;
            if (m_cnt >= TH) m_halt = 1;
        end
    endtask

    task automatic drive();
        bus.enable_i          = en;
        bus.clear_i           = clr;
        bus.instr_req_cls1_i  = c1.instr_req;
        bus.instr_req_cls2_i  = c2.instr_req;
        bus.instr_addr_cls1_i = c1.instr_addr;
        bus.instr_addr_cls2_i = c2.instr_addr;
        bus.data_req_cls1_i   = c1.data_req;
        bus.data_req_cls2_i   = c2.data_req;
        bus.data_we_cls1_i    = c1.data_we;
        bus.data_we_cls2_i    = c2.data_we;
        bus.data_be_cls1_i    = c1.data_be;
        bus.data_be_cls2_i    = c2.data_be;
        bus.data_addr_cls1_i  = c1.data_addr;
        bus.data_addr_cls2_i  = c2.data_addr;
        bus.data_wdata_cls1_i = c1.data_wdata;
        bus.data_wdata_cls2_i = c2.data_wdata;
        bus.core_busy_cls1_i  = c1.core_busy;
        bus.core_busy_cls2_i  = c2.core_busy;
    endtask

    task automatic step();
        core_bundle_t al;
        al = aligned();
        drive();
        @(posedge clk);
        model_edge(al);
        if (DLY > 0) begin
            hist.push_back(c1);
            void'(hist.pop_front());
        end
        #1;
        chk("mismatch_o", 32'(bus.mismatch_o), 32'(m_mis));
        chk("err_flag_o", 32'(bus.err_flag_o), 32'(m_flag));
        chk("err_count_o", 32'(bus.err_count_o), 32'(m_cnt));
        chk("err_src_o", 32'(bus.err_src_o), 32'(m_src));
        chk("halt_o", 32'(bus.halt_o), 32'(m_halt));
    endtask

    task automatic settle(int n);
        repeat (n) begin
            c2 = aligned();
            step();
        end
    endtask

    function automatic core_bundle_t rand_b();
        core_bundle_t b;
        b.instr_req  = $urandom_range(0, 3) != 0;
        b.instr_addr = $urandom;
        b.data_req   = $urandom_range(0, 2) != 0;
        b.data_we    = 1'($urandom);
        b.data_be    = 4'($urandom);
        b.data_addr  = $urandom;
        b.data_wdata = $urandom;
        b.core_busy  = 1'($urandom);
        return b;
    endfunction

    task automatic perturb();
        case ($urandom_range(0, 7))
            0: c2.instr_req  = ~c2.instr_req;
            1: c2.instr_addr ^= 32'd1 << $urandom_range(0, 31);
            2: c2.data_req   = ~c2.data_req;
            3: c2.data_we    = ~c2.data_we;
            4: c2.data_be    ^= 4'd1 << $urandom_range(0, 3);
            5: c2.data_addr  ^= 32'd1 << $urandom_range(0, 31);
            6: c2.data_wdata ^= 32'd1 << $urandom_range(0, 31);
            default: c2.core_busy = ~c2.core_busy;
        endcase
    endtask

    initial begin
        int seen;
        core_bundle_t base;
        en = 0; clr = 0; c1 = '0; c2 = '0;
        model_reset();
        drive();
        #12;
        chk("reset_mismatch", 32'(bus.mismatch_o), 32'd0);
        chk("reset_flag", 32'(bus.err_flag_o), 32'd0);
        chk("reset_count", 32'(bus.err_count_o), 32'd0);
        chk("reset_src", 32'(bus.err_src_o), 32'd0);
        chk("reset_halt", 32'(bus.halt_o), 32'd0);
        rst = 0;

        en = 1;
        seen = 0;
        repeat (100) begin
            c1 = rand_b();
            c2 = aligned();
            step();
            seen += int'(bus.mismatch_o);
        end
        chk("identical_mismatches", 32'(seen), 32'd0);
        chk("identical_count", 32'(bus.err_count_o), 32'd0);
        chk("identical_state", 32'(dut.state_q), 32'(CHECK));

        c1 = rand_b();
        c2 = aligned();
        c2.instr_req = ~c2.instr_req;
        step();
        chk("flip_mismatch", 32'(bus.mismatch_o), 32'd1);
        chk("flip_src", 32'(bus.err_src_o), 32'b0001);
        chk("flip_count", 32'(bus.err_count_o), 32'd1);
        chk("flip_flag", 32'(bus.err_flag_o), 32'd1);
        c1 = rand_b();
        c2 = aligned();
        step();
        chk("flip_single_pulse", 32'(bus.mismatch_o), 32'd0);

        base = rand_b();
        base.data_req = 1'b1;
        base.data_we  = 1'b0;
        c1 = base;
        clr = 1;
        settle(1);
        clr = 0;
        settle(2);
        c2 = aligned();
        c2.data_wdata ^= 32'h0000_00FF;
        step();
        chk("wdata_we0_mismatch", 32'(bus.mismatch_o), 32'd0);
        chk("wdata_we0_count", 32'(bus.err_count_o), 32'd0);
        c1.data_we = 1'b1;
        settle(DLY);
        c2 = aligned();
        c2.data_wdata ^= 32'h0000_00FF;
        step();
        chk("wdata_we1_mismatch", 32'(bus.mismatch_o), 32'd1);
        chk("wdata_we1_src", 32'(bus.err_src_o), 32'b0100);

        clr = 1;
        settle(1);
        clr = 0;
        settle(2);
        repeat (4) begin
            c2 = aligned();
            c2.core_busy = ~c2.core_busy;
            step();
        end
        chk("thresh_halt", 32'(bus.halt_o), 32'd1);
        chk("thresh_count", 32'(bus.err_count_o), 32'd4);
        c2 = aligned();
        c2.core_busy = ~c2.core_busy;
        step();
        chk("halt_fifth_count", 32'(bus.err_count_o), 32'd4);
        chk("halt_fifth_mismatch", 32'(bus.mismatch_o), 32'd0);

        clr = 1;
        settle(1);
        clr = 0;
        settle(2);
        c2 = aligned();
        c2.core_busy = ~c2.core_busy;
        clr = 1;
        step();
        clr = 0;
        chk("clr_win_count", 32'(bus.err_count_o), 32'd0);
        chk("clr_win_flag", 32'(bus.err_flag_o), 32'd0);
        chk("clr_win_mismatch", 32'(bus.mismatch_o), 32'd0);
        chk("clr_warm1", 32'(dut.state_q), 32'(WARMUP));
        settle(1);
        chk("clr_warm2", 32'(dut.state_q), 32'(WARMUP));
        settle(1);
        chk("clr_check", 32'(dut.state_q), 32'(CHECK));

        repeat (3) begin
            c2 = aligned();
            c2.core_busy = ~c2.core_busy;
            step();
        end
        chk("pre_rst_count", 32'(bus.err_count_o), 32'd3);
        chk("pre_rst_state", 32'(dut.state_q), 32'(ERROR));
        #2 rst = 1;
        #1;
        chk("rst_mismatch", 32'(bus.mismatch_o), 32'd0);
        chk("rst_flag", 32'(bus.err_flag_o), 32'd0);
        chk("rst_count", 32'(bus.err_count_o), 32'd0);
        chk("rst_src", 32'(bus.err_src_o), 32'd0);
        chk("rst_halt", 32'(bus.halt_o), 32'd0);
        model_reset();
        #2 rst = 0;
        chk("rst_release_state", 32'(dut.state_q), 32'(IDLE));
        en = 0;
        c1 = rand_b();
        c2 = aligned();
        step();
        chk("rst_idle_state", 32'(dut.state_q), 32'(IDLE));

        repeat (3000) begin
            en  = $urandom_range(0, 39) != 0;
            clr = $urandom_range(0, 59) == 0;
            c1  = rand_b();
            c2  = aligned();
            if ($urandom_range(0, 5) == 0) perturb();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lockstep_checker.md
LOCKSTEP_CHECKER -- requirements
Module: lockstep_checker

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL have parameter DELAY, default 2, meaning the cycles by which the cls2 stream lags cls1 (legal range 0..4).
REQ-003 The block SHALL have parameter ERR_THRESH, default 4, meaning the mismatch count at which halt asserts (legal range 1..255).
REQ-004 The block SHALL have port clk, input, 1, system clock.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port enable_i, input, 1, checking enable.
REQ-007 The block SHALL have port clear_i, input, 1, synchronous clear of count, flags and source.
REQ-008 The block SHALL have ports instr_req_cls{1,2}_i, input, 1 each, instruction request per core.
REQ-009 The block SHALL have ports instr_addr_cls{1,2}_i, input, 32 each, instruction address.
REQ-010 The block SHALL have ports data_req_cls{1,2}_i and data_we_cls{1,2}_i, input, 1 each, data request and write enable.
REQ-011 The block SHALL have ports data_be_cls{1,2}_i, input, 4 each, byte enables.
REQ-012 The block SHALL have ports data_addr_cls{1,2}_i and data_wdata_cls{1,2}_i, input, 32 each, data address and write data.
REQ-013 The block SHALL have ports core_busy_cls{1,2}_i, input, 1 each, core busy.
REQ-014 The block SHALL have port mismatch_o, output, 1, one-cycle pulse per detected mismatch.
REQ-015 The block SHALL have port err_flag_o, output, 1, sticky error flag.
REQ-016 The block SHALL have port err_count_o, output, 8, saturating mismatch count.
REQ-017 The block SHALL have port err_src_o, output, 4, groups that differed at the first mismatch.
REQ-018 The block SHALL have port halt_o, output, 1, threshold reached.

Function
REQ-019 The cls1 signals SHALL pass through a DELAY-stage register line; the cls2 signals at cycle t SHALL be compared with the cls1 signals from cycle t-DELAY. When DELAY=0 the line is bypassed.
REQ-020 Group G0 SHALL differ if instr_req differs, or if both instr_req are high and instr_addr differs.
REQ-021 Group G1 SHALL differ if data_req differs, or if both data_req are high and data_we or data_be differs.
REQ-022 Group G2 SHALL differ if both data_req are high and data_addr differs, or if both data_req and both data_we are high and data_wdata differs.
REQ-023 Group G3 SHALL differ if core_busy differs.
REQ-024 A mismatch SHALL be the OR of G0..G3; the comparison result is registered, so mismatch_o pulses exactly 1 cycle after the aligned sample.
REQ-025 The FSM SHALL have states IDLE, WARMUP, CHECK, ERROR and HALT.
REQ-026 From IDLE, enable_i=1 SHALL move to WARMUP. WARMUP SHALL last DELAY cycles (0 cycles when DELAY=0), ignore all compares, and then move to CHECK.
REQ-027 In CHECK, a mismatch SHALL move to ERROR, set err_flag_o, load err_src_o with the group bits and increment err_count_o.
REQ-028 In ERROR, each further mismatch SHALL increment err_count_o; err_src_o SHALL hold its value.
REQ-029 When err_count_o reaches ERR_THRESH the FSM SHALL move to HALT, with halt_o high in the same cycle the count reaches the threshold.
REQ-030 In HALT, counting and mismatch_o SHALL stop; only clear_i or rst exits HALT.
REQ-031 err_count_o SHALL saturate at 255 with no wrap.
REQ-032 enable_i=0 SHALL move any state other than HALT to IDLE, retaining count, flag and source; mismatch_o SHALL be 0 in IDLE.
REQ-033 clear_i SHALL zero count, flag, source and halt, and move to WARMUP if enable_i=1, otherwise to IDLE.
REQ-034 When clear_i and a mismatch occur in the same cycle, clear SHALL win and the mismatch SHALL be discarded.

Reset
REQ-035 rst SHALL force IDLE, zero the delay line, and drive all outputs to 0 asynchronously. Reset asserted mid-operation SHALL abort any WARMUP or ERROR state.

Structure
REQ-036 Package lockstep_pkg SHALL hold the FSM state enum, the G0..G3 bit-index constants and the core-bundle struct typedef.
REQ-037 The delay line SHALL be the sub-module lockstep_delay_line, parameterised by DELAY and operating on the bundle struct.

Verification
REQ-038 Identical streams with DELAY=2 for 100 cycles SHALL keep mismatch_o=0 and err_count_o=0.
REQ-039 A single flip of cls2 instr_req SHALL produce one mismatch_o pulse 1 cycle later, with err_src_o=4'b0001, err_count_o=1 and err_flag_o=1.
REQ-040 A data_wdata difference while data_we=0 SHALL produce no mismatch; the same difference with data_we=1 SHALL give err_src_o=4'b0100.
REQ-041 Four mismatches with ERR_THRESH=4 SHALL give halt_o=1 and err_count_o=4; a fifth mismatch SHALL leave the count at 4.
REQ-042 clear_i asserted in the same cycle as a mismatch SHALL give count 0, flag 0, WARMUP for 2 cycles and then CHECK.
REQ-043 rst asserted during ERROR with count 3 SHALL immediately zero all outputs, and the FSM SHALL be in IDLE after release.
